// File: rtl/conv_scheduler.sv
// Two-requester round-robin front end for a convolution engine: latches the
// winner's operands, fires a start pulse, and acks on completion or timeout.
module conv_scheduler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] z0,
  input  logic       req1,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic [7:0] z1,
  output logic       ack0,
  output logic       ack1,
  output logic       timeout_err,
  output logic       busy,
  output logic       owner,
  output logic       eng_start,
  output logic [7:0] eng_x,
  output logic [7:0] eng_y,
  output logic [7:0] eng_z,
  input  logic       eng_done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        owner_q, last_q, tmo_q;
  logic        grant, any_req, terminal;

  assign any_req  = req0 | req1;
  // On a tie the requester that was not served last wins.
  assign grant    = (req0 && req1) ? ~last_q : req1;
  assign terminal = (cnt_q == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = RUN;
      RUN:     if (eng_done || terminal) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= 1'b0;
      eng_x   <= 8'd0;
      eng_y   <= 8'd0;
      eng_z   <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (any_req) owner_q <= grant;
        LOAD: begin
          eng_x <= owner_q ? x1 : x0;
          eng_y <= owner_q ? y1 : y0;
          eng_z <= owner_q ? z1 : z0;
          cnt_q <= 16'd0;
          tmo_q <= 1'b0;
        end
        RUN: begin
          if (!terminal) cnt_q <= cnt_q + 16'd1;
          // A completion on the terminal cycle is not a timeout.
          tmo_q <= ~eng_done & terminal;
        end
        DONE: last_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign eng_start   = (state_q == START);
  assign ack0        = (state_q == DONE) & ~owner_q;
  assign ack1        = (state_q == DONE) &  owner_q;
  assign timeout_err = (state_q == DONE) &  tmo_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler: jobs predicted from arbitration and
// latency rules, checked by an independent monitor and a behavioural engine.
module tb_conv_scheduler;
  localparam int T = 8;

  logic       clk = 0, rst = 1;
  logic       req0 = 0, req1 = 0;
  logic [7:0] x0 = 0, y0 = 0, z0 = 0, x1 = 0, y1 = 0, z1 = 0;
  logic       ack0, ack1, timeout_err, busy, owner, eng_start;
  logic [7:0] eng_x, eng_y, eng_z;
  logic       eng_done_e = 0, eng_done_x = 0;
  logic       eng_done;
  assign eng_done = eng_done_e | eng_done_x;

  conv_scheduler #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .y0(y0), .z0(z0),
    .req1(req1), .x1(x1), .y1(y1), .z1(z1),
    .ack0(ack0), .ack1(ack1), .timeout_err(timeout_err), .busy(busy),
    .owner(owner), .eng_start(eng_start),
    .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    bit         own;
    logic [7:0] x, y, z;
    int         cy;
    bit         tmo;
  } exp_t;

  exp_t start_q[$], ack_q[$];
  int   eng_q[$];
  bit   pend0 = 0, pend1 = 0, last = 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Engine: asserts eng_done k cycles after eng_start; k == 0 means never.
  initial begin
    int ecnt = 0;
    forever begin
      @(negedge clk);
      eng_done_e = 0;
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) eng_done_e = 1;
      end
      if (eng_start) begin
        if (eng_q.size() > 0) ecnt = eng_q.pop_front();
        else ecnt = 0;
      end
    end
  end

  // Monitor: every start and ack must match the next predicted job.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        chk("start_ack_excl", ack0 | ack1, 0);
        if (start_q.size() == 0) fail("spurious_start");
        else begin
          e = start_q.pop_front();
          chk("start_cycle", cyc, e.cy);
          chk("start_owner", owner, e.own);
          chk("eng_xyz", {eng_x, eng_y, eng_z}, {e.x, e.y, e.z});
        end
      end
      if (ack0 || ack1) begin
        chk("ack_onehot", ack0 & ack1, 0);
        if (ack_q.size() == 0) fail("spurious_ack");
        else begin
          e = ack_q.pop_front();
          chk("ack0", ack0, !e.own);
          chk("ack1", ack1, e.own);
          chk("timeout_err", timeout_err, e.tmo);
          chk("ack_cycle", cyc, e.cy);
          chk("hold_xyz", {eng_x, eng_y, eng_z}, {e.x, e.y, e.z});
        end
      end else if (timeout_err) fail("stray_timeout_err");
    end
  end

  // Raise requests, predict the winner and its timing, wait for its ack.
  task automatic run_job(input bit n0, input bit n1, input int k, input bit drop,
                         input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] zv);
    bit   w, tmo, got;
    int   lat;
    exp_t e;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) fail("idle_wait");
    if (n0 && !pend0) begin pend0 = 1; x0 = xv; y0 = yv; z0 = zv; end
    if (n1 && !pend1) begin pend1 = 1; x1 = zv; y1 = xv; z1 = yv; end
    if (!pend0 && !pend1) begin pend0 = 1; x0 = xv; y0 = yv; z0 = zv; end
    w    = (pend0 && pend1) ? !last : pend1;
    last = w;
    tmo  = (k == 0) || (k > T);
    lat  = tmo ? T : k;
    e.own = w;
    e.x   = w ? x1 : x0;
    e.y   = w ? y1 : y0;
    e.z   = w ? z1 : z0;
    e.tmo = tmo;
    e.cy  = cyc + 2;
    start_q.push_back(e);
    e.cy  = cyc + 3 + lat;
    ack_q.push_back(e);
    eng_q.push_back(k);
    req0 = pend0;
    req1 = pend1;
    got  = 0;
    for (int i = 0; i < T + 40 && !got; i++) begin
      @(negedge clk);
      if (drop && i == 4) begin
        if (w) begin pend1 = 0; req1 = 0; end
        else   begin pend0 = 0; req0 = 0; end
      end
      if (ack0) begin pend0 = 0; req0 = 0; got = 1; end
      if (ack1) begin pend1 = 0; req1 = 0; got = 1; end
    end
    if (!got) fail("ack_wait");
  endtask

  task automatic drain();
    while (pend0 || pend1) run_job(0, 0, 2, 0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, ack0, ack1, timeout_err, eng_start, owner}, 0);
    chk("rst_xyz", {eng_x, eng_y, eng_z}, 0);
    rst = 0;

    // Both held from reset: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++) run_job(1, 1, 3, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    drain();

    run_job(1, 0, 5, 0, 8'h10, 8'h20, 8'h30);
    @(negedge clk);
    chk("busy_after_ack", busy, 0);

    run_job(0, 1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    run_job(1, 0, T, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    run_job(0, 1, T + 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    run_job(1, 0, 6, 1, 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (2) @(negedge clk);
    chk("no_job_after_drop", busy, 0);

    for (int i = 0; i < 40; i++)
      run_job(1'($urandom), 1'($urandom), int'($urandom_range(0, T + 3)),
              ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom), 8'($urandom));
    drain();

    // Engine completion while idle must not produce an ack.
    repeat (2) @(negedge clk);
    eng_done_x = 1;
    @(negedge clk);
    eng_done_x = 0;
    repeat (3) @(negedge clk);
    chk("idle_done_busy", busy, 0);

    // Reset during RUN aborts silently.
    pend1 = 1; req1 = 1;
    x1 = 8'($urandom); y1 = 8'($urandom); z1 = 8'($urandom);
    e.own = 1; e.x = x1; e.y = y1; e.z = z1; e.tmo = 0; e.cy = cyc + 2;
    start_q.push_back(e);
    eng_q.push_back(0);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1; req1 = 0; pend1 = 0;
    @(negedge clk);
    rst = 0;
    last = 1;
    chk("rst_mid_outputs", {busy, ack0, ack1, timeout_err, eng_start, owner}, 0);
    chk("rst_mid_xyz", {eng_x, eng_y, eng_z}, 0);
    run_job(0, 1, 4, 0, 8'($urandom), 8'($urandom), 8'($urandom));

    repeat (5) @(negedge clk);
    chk("start_q_empty", start_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd4096, RUN-state cycle limit before a job is aborted (legal 2..65535).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 job request, level, held until ack0.
REQ-005 x0  input  8  requester 0 x operand, stable while req0 high.
REQ-006 y0  input  8  requester 0 y operand, stable while req0 high.
REQ-007 z0  input  8  requester 0 z operand, stable while req0 high.
REQ-008 req1  input  1  requester 1 job request, level, held until ack1.
REQ-009 x1  input  8  requester 1 x operand.
REQ-010 y1  input  8  requester 1 y operand.
REQ-011 z1  input  8  requester 1 z operand.
REQ-012 ack0  output  1  one-cycle pulse: requester 0 job finished.
REQ-013 ack1  output  1  one-cycle pulse: requester 1 job finished.
REQ-014 timeout_err  output  1  one-cycle pulse coincident with ack when job timed out.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 owner  output  1  index of requester currently served; valid while busy.
REQ-017 eng_start  output  1  one-cycle start pulse to convolution engine.
REQ-018 eng_x  output  8  x operand to engine (registered).
REQ-019 eng_y  output  8  y operand to engine (registered).
REQ-020 eng_z  output  8  z operand to engine (registered).
REQ-021 eng_done  input  1  engine completion pulse.

Function
REQ-022 FSM states IDLE, LOAD, START, RUN, DONE; one transition per clock, no other states reachable.
REQ-023 IDLE: no req -> stay; any req -> LOAD, owner <= granted index.
REQ-024 Arbitration round-robin: single req wins; both req -> index != last_owner wins.
REQ-025 LOAD: eng_x/y/z <= granted requester's x/y/z; timeout counter <= 0; -> START.
REQ-026 START: eng_start = 1 for exactly this cycle; -> RUN.
REQ-027 RUN: counter +1 per cycle (16-bit, no wrap past TIMEOUT_CYCLES-1); eng_done -> DONE ok; counter == TIMEOUT_CYCLES-1 without eng_done -> DONE timed-out.
REQ-028 eng_done and timeout terminal in same cycle -> completion wins, timeout_err = 0.
REQ-029 DONE: ack[owner] = 1, timeout_err = timed-out flag, last_owner <= owner; -> IDLE.
REQ-030 Latency: req seen in IDLE at cycle t -> eng_start at t+2; eng_done at cycle d -> ack at d+1; next grant earliest d+2.
REQ-031 req sampled only in IDLE; req drop during LOAD..DONE ignored, job completes and ack still issued.
REQ-032 req still high in IDLE after its ack = new job (back-to-back permitted, subject to REQ-024).
REQ-033 eng_done outside RUN ignored; no spurious ack.
REQ-034 eng_x/y/z constant from LOAD through DONE; hold last value in IDLE.
REQ-035 ack0 and ack1 never high together; ack, eng_start never high in same cycle.

Reset
REQ-036 rst high at a clock edge: state <= IDLE, counter <= 0, last_owner <= 1 (requester 0 wins first tie), all outputs <= 0 next cycle.
REQ-037 rst mid-job: job aborted silently, no ack, no timeout_err, eng_start low; rst has priority over every transition.

Verification
REQ-038 req0=1, x0/y0/z0=8'h10/20/30, eng_done 5 cycles after eng_start -> eng_start at t+2, eng_x/y/z=10/20/30, ack0 pulse one cycle after eng_done, busy low after.
REQ-039 req0=req1=1 from reset, held, engine done after 3 cycles each -> grants 0,1,0,1 alternating, acks never overlap.
REQ-040 TIMEOUT_CYCLES=8, eng_done never -> ack1 and timeout_err high together 8 cycles after RUN entry, then IDLE.
REQ-041 eng_done on the timeout terminal cycle -> ack with timeout_err=0; eng_done pulse in IDLE -> no ack.
REQ-042 rst asserted in RUN -> next cycle busy=0, eng_start=0, no ack; subsequent req1 served normally.
REQ-043 req0 dropped during RUN -> ack0 still pulsed at completion; no new job started.
